// File: rtl/rca_config_sequencer_if.sv
// Bundles the decode/issue request, RCA issue accounting, config memory read
// port and RCA config register write port of the RCA configuration sequencer.
interface rca_config_sequencer_if #(
    parameter int unsigned NUM_CONFIGS = 4,
    parameter int unsigned CFG_WORDS   = 8
);
    localparam int unsigned CFG_ID_W = $clog2(NUM_CONFIGS);
    localparam int unsigned ADDR_W   = $clog2(NUM_CONFIGS * CFG_WORDS);
    localparam int unsigned IDX_W    = $clog2(CFG_WORDS);

    logic                cfg_req_valid;
    logic [CFG_ID_W:0]   cfg_req_id;
    logic                cfg_req_ready;
    logic                cfg_req_err;
    logic                issue_fire;
    logic                retire_fire;
    logic                issue_allow;
    logic                cfg_rd_en;
    logic [ADDR_W-1:0]   cfg_rd_addr;
    logic [31:0]         cfg_rd_data;
    logic                cfg_wr_en;
    logic [IDX_W-1:0]    cfg_wr_idx;
    logic [31:0]         cfg_wr_data;
    logic [CFG_ID_W-1:0] active_cfg_id;
    logic                active_cfg_valid;
    logic                busy;

    // Requester, RCA unit and config memory side.
    modport master (
        output cfg_req_valid, cfg_req_id, issue_fire, retire_fire, cfg_rd_data,
        input  cfg_req_ready, cfg_req_err, issue_allow, cfg_rd_en, cfg_rd_addr,
               cfg_wr_en, cfg_wr_idx, cfg_wr_data, active_cfg_id, active_cfg_valid, busy
    );

    // Sequencer side.
    modport slave (
        input  cfg_req_valid, cfg_req_id, issue_fire, retire_fire, cfg_rd_data,
        output cfg_req_ready, cfg_req_err, issue_allow, cfg_rd_en, cfg_rd_addr,
               cfg_wr_en, cfg_wr_idx, cfg_wr_data, active_cfg_id, active_cfg_valid, busy
    );
endinterface

// File: rtl/rca_config_sequencer.sv
// Sequences RCA reconfiguration: drain in-flight ops, stream config words from
// the config store into the RCA config registers, settle, then re-enable issue.
module rca_config_sequencer #(
    parameter int unsigned NUM_CONFIGS   = 4,
    parameter int unsigned CFG_WORDS     = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_INFLIGHT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rca_config_sequencer_if.slave bus
);
    localparam int unsigned CFG_ID_W    = $clog2(NUM_CONFIGS);
    localparam int unsigned REQ_ID_W    = CFG_ID_W + 1;
    localparam int unsigned ADDR_W      = $clog2(NUM_CONFIGS * CFG_WORDS);
    localparam int unsigned IDX_W       = $clog2(CFG_WORDS);
    localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned WCNT_W      = $clog2(CFG_WORDS + 1);
    localparam int unsigned SCNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    state_e              state_q,        state_d;
    logic [CFG_ID_W-1:0] target_id_q,    target_id_d;
    logic [CFG_ID_W-1:0] active_id_q,    active_id_d;
    logic                active_valid_q, active_valid_d;
    logic [CNT_W-1:0]    inflight_q,     inflight_d;
    logic [WCNT_W-1:0]   word_q,         word_d;
    logic [SCNT_W-1:0]   settle_q,       settle_d;
    logic                rd_en_q,        rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q,      rd_addr_d;
    logic                wr_en_q,        wr_en_d;
    logic [IDX_W-1:0]    wr_idx_q,       wr_idx_d;

    logic                req_in_range;
    logic                req_hit;
    logic                req_miss;
    logic [ADDR_W-1:0]   target_base;

    // Request classification against the currently loaded configuration.
    always_comb begin
        req_in_range = bus.cfg_req_id < REQ_ID_W'(NUM_CONFIGS);
        req_hit      = bus.cfg_req_valid && req_in_range && active_valid_q &&
                       (bus.cfg_req_id[CFG_ID_W-1:0] == active_id_q);
        req_miss     = bus.cfg_req_valid && req_in_range && !req_hit;
        target_base  = ADDR_W'(target_id_q) * ADDR_W'(CFG_WORDS);
    end

    // Outstanding RCA ops; simultaneous issue and retire cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (bus.issue_fire && !bus.retire_fire) begin
            if (inflight_q != {CNT_W{1'b1}}) begin
                inflight_d = inflight_q + CNT_W'(1);
            end
        end else if (bus.retire_fire && !bus.issue_fire && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        target_id_d    = target_id_q;
        active_id_d    = active_id_q;
        active_valid_d = active_valid_q;
        word_d         = word_q;
        settle_d       = settle_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        wr_en_d        = rd_en_q;
        wr_idx_d       = wr_idx_q;

        case (state_q)
            ST_READY: begin
                if (req_miss) begin
                    target_id_d = bus.cfg_req_id[CFG_ID_W-1:0];
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d        = ST_LOAD;
                    active_valid_d = 1'b0;
                    word_d         = '0;
                    rd_en_d        = 1'b1;
                    rd_addr_d      = target_base;
                end
            end
            ST_LOAD: begin
                // Data for the read issued this cycle lands one cycle later.
                if (rd_en_q) begin
                    wr_idx_d = IDX_W'(word_q);
                end
                if (word_q == WCNT_W'(CFG_WORDS)) begin
                    state_d  = ST_SETTLE;
                    settle_d = SCNT_W'(SETTLE_LAST);
                end else begin
                    word_d = word_q + WCNT_W'(1);
                    if (word_q < WCNT_W'(CFG_WORDS - 1)) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d        = ST_READY;
                    active_id_d    = target_id_q;
                    active_valid_d = 1'b1;
                end else begin
                    settle_d = settle_q - SCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_READY;
            target_id_q    <= '0;
            active_id_q    <= '0;
            active_valid_q <= 1'b0;
            inflight_q     <= '0;
            word_q         <= '0;
            settle_q       <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_idx_q       <= '0;
        end else begin
            state_q        <= state_d;
            target_id_q    <= target_id_d;
            active_id_q    <= active_id_d;
            active_valid_q <= active_valid_d;
            inflight_q     <= inflight_d;
            word_q         <= word_d;
            settle_q       <= settle_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            wr_en_q        <= wr_en_d;
            wr_idx_q       <= wr_idx_d;
        end
    end

    assign bus.cfg_req_ready    = (state_q == ST_READY) && req_hit;
    assign bus.cfg_req_err      = (state_q == ST_READY) && bus.cfg_req_valid && !req_in_range;
    assign bus.issue_allow      = (state_q == ST_READY) && active_valid_q &&
                                  (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign bus.busy             = (state_q != ST_READY);
    assign bus.cfg_rd_en        = rd_en_q;
    assign bus.cfg_rd_addr      = rd_addr_q;
    assign bus.cfg_wr_en        = wr_en_q;
    assign bus.cfg_wr_idx       = wr_idx_q;
    // Memory read data flows straight into the write port on its arrival cycle.
    assign bus.cfg_wr_data      = wr_en_q ? bus.cfg_rd_data : 32'h0;
    assign bus.active_cfg_id    = active_id_q;
    assign bus.active_cfg_valid = active_valid_q;
endmodule

// File: tb/tb_rca_config_sequencer.sv
// Bench for rca_config_sequencer: directed steps plus random requests, checked
// against a transaction-level model of load latency, addresses and issue gating.
module tb_rca_config_sequencer;
    localparam int unsigned NUM_CONFIGS   = 4;
    localparam int unsigned CFG_WORDS     = 8;
    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int unsigned MAX_INFLIGHT  = 4;
    localparam int unsigned ADDR_W        = $clog2(NUM_CONFIGS * CFG_WORDS);
    localparam int unsigned MEM_DEPTH     = NUM_CONFIGS * CFG_WORDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rca_config_sequencer_if #(.NUM_CONFIGS(NUM_CONFIGS), .CFG_WORDS(CFG_WORDS)) bus ();

    rca_config_sequencer #(
        .NUM_CONFIGS  (NUM_CONFIGS),
        .CFG_WORDS    (CFG_WORDS),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [MEM_DEPTH];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_inflight;
    int          m_active_id;
    bit          m_active_valid;

    // Config store: one-cycle read latency.
    always @(posedge clk) begin
        bus.cfg_rd_data <= bus.cfg_rd_en ? mem[bus.cfg_rd_addr] : 32'h0;
    end

    // Reference in-flight count: issue adds, retire subtracts, never below zero.
    always @(posedge clk or posedge rst) begin
        if (rst) m_inflight <= 0;
        else if (bus.issue_fire && !bus.retire_fire) m_inflight <= m_inflight + 1;
        else if (bus.retire_fire && !bus.issue_fire && m_inflight > 0) m_inflight <= m_inflight - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_allow();
        return 32'(m_active_valid && (m_inflight < int'(MAX_INFLIGHT)));
    endfunction

    task automatic pulse(input bit iss, input bit ret);
        bus.issue_fire  = iss;
        bus.retire_fire = ret;
        @(negedge clk);
        bus.issue_fire  = 1'b0;
        bus.retire_fire = 1'b0;
    endtask

    // Miss: drains any in-flight ops (optionally one issue+retire cycle) and checks the load.
    task automatic run_miss(input int id, input bit both);
        int  base, exp_rd, first_rd, lat, n_rd, n_wr;
        bit  ready_seen, rd_bad, wr_bad, allow_bad;
        base = id * int'(CFG_WORDS);
        exp_rd = -1; first_rd = -1; lat = -1; n_rd = 0; n_wr = 0;
        ready_seen = 0; rd_bad = 0; wr_bad = 0; allow_bad = 0;
        bus.cfg_req_valid = 1'b1;
        bus.cfg_req_id    = 3'(id);
        for (int t = 0; t < 300 && !ready_seen; t++) begin
            bus.retire_fire = (t >= 1) && (m_inflight > 0);
            bus.issue_fire  = both && (t == 2) && (m_inflight > 0);
            #1;
            if (t >= 1 && exp_rd < 0 && m_inflight == 0) exp_rd = t + 1;
            if (bus.cfg_req_ready) begin
                ready_seen = 1;
                lat = t;
                chk("busy_at_ready", 32'(bus.busy), 32'd0);
                chk("active_id", 32'(bus.active_cfg_id), 32'(id));
                chk("active_valid", 32'(bus.active_cfg_valid), 32'd1);
            end else if (t >= 1 && bus.issue_allow) begin
                allow_bad = 1;
            end
            if (bus.cfg_rd_en) begin
                if (n_rd == 0) first_rd = t;
                if (bus.cfg_rd_addr !== ADDR_W'(base + n_rd) || t != first_rd + n_rd) rd_bad = 1;
                n_rd++;
            end
            if (bus.cfg_wr_en) begin
                if (bus.cfg_wr_idx !== 3'(n_wr) || bus.cfg_wr_data !== mem[base + n_wr] ||
                    t != first_rd + n_wr + 1) wr_bad = 1;
                n_wr++;
            end
            @(negedge clk);
        end
        bus.cfg_req_valid = 1'b0;
        bus.issue_fire    = 1'b0;
        bus.retire_fire   = 1'b0;
        chk("ready_timeout", 32'(ready_seen), 32'd1);
        chk("first_read_cycle", 32'(first_rd), 32'(exp_rd));
        chk("latency", 32'(lat), 32'(exp_rd + int'(CFG_WORDS) + 1 + int'(SETTLE_CYCLES)));
        chk("read_count", 32'(n_rd), 32'(CFG_WORDS));
        chk("write_count", 32'(n_wr), 32'(CFG_WORDS));
        chk("read_seq", 32'(rd_bad), 32'd0);
        chk("write_seq", 32'(wr_bad), 32'd0);
        chk("allow_low_in_seq", 32'(allow_bad), 32'd0);
        m_active_id    = id;
        m_active_valid = 1;
    endtask

    task automatic do_hit(input int id);
        bus.cfg_req_valid = 1'b1;
        bus.cfg_req_id    = 3'(id);
        #1;
        chk("hit_ready", 32'(bus.cfg_req_ready), 32'd1);
        chk("hit_err", 32'(bus.cfg_req_err), 32'd0);
        chk("hit_rd_en", 32'(bus.cfg_rd_en), 32'd0);
        @(negedge clk);
        #1;
        chk("hit_busy", 32'(bus.busy), 32'd0);
        chk("hit_rd_en_next", 32'(bus.cfg_rd_en), 32'd0);
        bus.cfg_req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_oor(input int id);
        bus.cfg_req_valid = 1'b1;
        bus.cfg_req_id    = 3'(id);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("oor_err", 32'(bus.cfg_req_err), 32'd1);
            chk("oor_ready", 32'(bus.cfg_req_ready), 32'd0);
            chk("oor_busy", 32'(bus.busy), 32'd0);
            chk("oor_rd_en", 32'(bus.cfg_rd_en), 32'd0);
            @(negedge clk);
        end
        bus.cfg_req_valid = 1'b0;
        #1;
        chk("oor_err_drop", 32'(bus.cfg_req_err), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = $urandom;
        m_active_id = 0; m_active_valid = 0;
        rst = 1'b1;
        bus.cfg_req_valid = 1'b0; bus.cfg_req_id = '0;
        bus.issue_fire = 1'b0; bus.retire_fire = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_active_valid", 32'(bus.active_cfg_valid), 32'd0);
        chk("rst_active_id", 32'(bus.active_cfg_id), 32'd0);
        chk("rst_rd_en", 32'(bus.cfg_rd_en), 32'd0);
        chk("rst_wr_en", 32'(bus.cfg_wr_en), 32'd0);
        chk("rst_allow", 32'(bus.issue_allow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // First load, then a hit on the same configuration.
        run_miss(2, 0);
        do_hit(2);

        // Fill to the in-flight limit, retire back, retire once more at zero.
        for (int i = 0; i < 4; i++) begin
            #1; chk("allow_pre_issue", 32'(bus.issue_allow), exp_allow());
            pulse(1, 0);
        end
        #1; chk("allow_saturated", 32'(bus.issue_allow), exp_allow());
        pulse(0, 1);
        #1; chk("allow_after_retire", 32'(bus.issue_allow), exp_allow());
        repeat (4) pulse(0, 1);
        for (int i = 0; i < 4; i++) begin
            #1; chk("allow_refill", 32'(bus.issue_allow), exp_allow());
            pulse(1, 0);
        end
        #1; chk("allow_refill_full", 32'(bus.issue_allow), exp_allow());
        pulse(0, 1);

        // Switch configuration with three ops outstanding.
        run_miss(1, 1);

        do_oor(5);
        do_oor(4);
        do_oor(7);

        // Reset while streaming word 3 of configuration 3.
        found = 0;
        bus.cfg_req_valid = 1'b1;
        bus.cfg_req_id    = 3'd3;
        for (int t = 0; t < 40 && !found; t++) begin
            #1;
            if (bus.cfg_rd_en && bus.cfg_rd_addr == ADDR_W'(3 * CFG_WORDS + 3)) found = 1;
            else @(negedge clk);
        end
        chk("reach_load_word3", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rd_en", 32'(bus.cfg_rd_en), 32'd0);
        chk("midrst_wr_en", 32'(bus.cfg_wr_en), 32'd0);
        chk("midrst_active_valid", 32'(bus.active_cfg_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ready", 32'(bus.cfg_req_ready), 32'd0);
        bus.cfg_req_valid = 1'b0;
        m_active_id = 0; m_active_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_miss(3, 0);

        // Random requests with random in-flight preload.
        for (int r = 0; r < 14; r++) begin
            int id, n;
            id = ($urandom_range(0, 2) == 0) ? m_active_id : int'($urandom_range(0, 7));
            n  = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) if (m_inflight < int'(MAX_INFLIGHT)) pulse(1, 0);
            #1; chk("rand_allow", 32'(bus.issue_allow), exp_allow());
            @(negedge clk);
            if (id >= int'(NUM_CONFIGS)) do_oor(id);
            else if (m_active_valid && id == m_active_id) do_hit(id);
            else run_miss(id, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
